// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table stimulus sequencer.
// Compare logic in the top is gated by TT_COMPARE_EN.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int CNT_W = 4;

    function automatic int ncomb(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Loadable down-counter that parks at zero and flags it.
// Used to hold each input combination for its settle time.
module tt_settle_counter
    import tt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tt_stimulus_sequencer.sv
// Sweeps all input combinations of an expression and captures its truth table.
// Define TT_COMPARE_EN to build the registered table/expected compare.
module tt_stimulus_sequencer
    import tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [N_IN-1:0]         x_out,
    input  logic                    dut_result,
    output logic                    busy,
    output logic                    done,
    output logic [ncomb(N_IN)-1:0]  table_out,
    input  logic [ncomb(N_IN)-1:0]  expected,
    output logic                    match
);

    localparam int NC = ncomb(N_IN);
    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

    state_t          state, state_n;
    logic [N_IN-1:0] combo, combo_n;
    logic [NC-1:0]   tbl, tbl_n;
    logic            busy_n, done_n;
    logic            load, accept, finish, zero;

    tt_settle_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (SETTLE_V),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            combo <= '0;
            tbl   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            combo <= combo_n;
            tbl   <= tbl_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        combo_n = combo;
        tbl_n   = tbl;
        busy_n  = busy;
        done_n  = done;
        load    = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    combo_n = '0;
                    tbl_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    load    = 1'b1;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (zero) begin
                    tbl_n[combo] = dut_result;
                    if (&combo) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        finish  = 1'b1;
                    end else begin
                        combo_n = combo + 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign x_out     = combo;
    assign table_out = tbl;

`ifdef TT_COMPARE_EN
    logic match_q;

    // Compare the final table including the bit captured on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else if (finish) begin
            match_q <= (tbl_n == expected);
        end else if (accept) begin
            match_q <= 1'b0;
        end
    end

    assign match = match_q;
`else
    logic unused_ok;

    assign unused_ok = accept & finish & (^expected);
    assign match     = 1'b0 & unused_ok;
`endif

endmodule

// File: tb/tb_tt_stimulus_sequencer.sv
// Scoreboard bench for the truth-table stimulus sequencer.
// Three instances cover the default, zero-settle and 3-input configurations.
module tb_tt_stimulus_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = '0;

    logic [1:0] x0, x1;
    logic [2:0] x2;
    logic       r0, r1, r2;
    logic [2:0] busy_v, done_v, match_v;
    logic [3:0] t0, t1;
    logic [7:0] t2;
    logic [3:0] exp0 = 4'b1100;
    logic [3:0] exp1 = 4'b1000;
    logic [7:0] exp2 = 8'b10010110;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    int         xq[$];
    logic [7:0] tq[$];

    int         obs_x;
    logic       obs_busy, obs_done, obs_match;
    logic [7:0] obs_table, obs_exp;

    always #5 clk = ~clk;

    assign r0 = (~(~x0[1] & x0[0])) & (~(~x0[1] & ~x0[0]));
    assign r1 = x1[1] & x1[0];
    assign r2 = ^x2;

    tt_stimulus_sequencer #(.N_IN(2), .SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .x_out(x0),
        .dut_result(r0), .busy(busy_v[0]), .done(done_v[0]),
        .table_out(t0), .expected(exp0), .match(match_v[0])
    );

    tt_stimulus_sequencer #(.N_IN(2), .SETTLE(0)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .x_out(x1),
        .dut_result(r1), .busy(busy_v[1]), .done(done_v[1]),
        .table_out(t1), .expected(exp1), .match(match_v[1])
    );

    tt_stimulus_sequencer #(.N_IN(3), .SETTLE(2)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .x_out(x2),
        .dut_result(r2), .busy(busy_v[2]), .done(done_v[2]),
        .table_out(t2), .expected(exp2), .match(match_v[2])
    );

    always_comb begin
        obs_x     = 0;
        obs_busy  = 1'b0;
        obs_done  = 1'b0;
        obs_match = 1'b0;
        obs_table = '0;
        obs_exp   = '0;
        case (sel)
            0: begin
                obs_x = int'(x0); obs_busy = busy_v[0]; obs_done = done_v[0];
                obs_match = match_v[0]; obs_table = {4'b0, t0}; obs_exp = {4'b0, exp0};
            end
            1: begin
                obs_x = int'(x1); obs_busy = busy_v[1]; obs_done = done_v[1];
                obs_match = match_v[1]; obs_table = {4'b0, t1}; obs_exp = {4'b0, exp1};
            end
            default: begin
                obs_x = int'(x2); obs_busy = busy_v[2]; obs_done = done_v[2];
                obs_match = match_v[2]; obs_table = t2; obs_exp = exp2;
            end
        endcase
    end

    function automatic logic want_match(input logic [7:0] tbl, input logic [7:0] ex);
`ifdef TT_COMPARE_EN
        return tbl == ex;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            total++;
            if (obs_x !== 0 || obs_busy !== 1'b0 || obs_done !== 1'b0 ||
                obs_table !== 8'h00 || obs_match !== 1'b0) begin
                bad++;
                $display("FAIL reset[%0d]: x=%0d busy=%b done=%b tbl=%h match=%b want all 0",
                         s, obs_x, obs_busy, obs_done, obs_table, obs_match);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one sweep; expected x_out per cycle and final table go through queues.
    task automatic sweep(input int s, input int n, input int settle,
                         input logic [7:0] tbl, input logic hold, input string nm);
        int         cyc;
        int         ex;
        logic [7:0] et;
        logic       em;
        cyc = (1 << n) * (settle + 1);
        @(negedge clk);
        sel = s;
        start_v[s] = 1'b1;
        for (int j = 0; j < cyc; j++) xq.push_back(j / (settle + 1));
        tq.push_back(tbl);
        @(posedge clk);
        #1;
        if (!hold) start_v[s] = 1'b0;
        for (int j = 0; j < cyc; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            ex = xq.pop_front();
            total++;
            if (obs_x !== ex || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
                bad++;
                $display("FAIL %s run c%0d: x=%0d busy=%b done=%b want x=%0d busy=1 done=0",
                         nm, j, obs_x, obs_busy, obs_done, ex);
            end
        end
        @(posedge clk);
        #1;
        et = tq.pop_front();
        em = want_match(et, obs_exp);
        total++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s end: done=%b busy=%b want done=1 busy=0",
                     nm, obs_done, obs_busy);
        end
        total++;
        if (obs_table !== et) begin
            bad++;
            $display("FAIL %s table: got %b want %b", nm, obs_table, et);
        end
        total++;
        if (obs_match !== em) begin
            bad++;
            $display("FAIL %s match: got %b want %b", nm, obs_match, em);
        end
        if (hold) begin
            @(posedge clk);
            #1;
            total++;
            if (obs_done !== 1'b0 || obs_busy !== 1'b1 || obs_x !== 0 ||
                obs_table !== 8'h00 || obs_match !== 1'b0) begin
                bad++;
                $display("FAIL %s rearm: done=%b busy=%b x=%0d tbl=%h m=%b want 0 1 0 00 0",
                         nm, obs_done, obs_busy, obs_x, obs_table, obs_match);
            end
            start_v[s] = 1'b0;
            repeat (cyc) @(posedge clk);
            #1;
            total++;
            if (obs_done !== 1'b1 || obs_table !== tbl) begin
                bad++;
                $display("FAIL %s rerun: done=%b tbl=%b want done=1 tbl=%b",
                         nm, obs_done, obs_table, tbl);
            end
        end
    endtask

    task automatic test_basic();
        exp0 = 4'b1100;
        sweep(0, 2, 1, 8'b00001100, 1'b0, "basic");
    endtask

    task automatic test_mismatch();
        exp0 = 4'b1010;
        sweep(0, 2, 1, 8'b00001100, 1'b0, "mismatch");
        exp0 = 4'b1100;
    endtask

    task automatic test_settle0();
        sweep(1, 2, 0, 8'b00001000, 1'b0, "settle0");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        sel = 0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_table !== 8'h00 ||
            obs_x !== 0 || obs_match !== 1'b0) begin
            bad++;
            $display("FAIL midreset: busy=%b done=%b tbl=%h x=%0d m=%b want all 0",
                     obs_busy, obs_done, obs_table, obs_x, obs_match);
        end
        @(negedge clk);
        rst = 1'b0;
        sweep(0, 2, 1, 8'b00001100, 1'b0, "after_reset");
    endtask

    task automatic test_hold_start();
        sweep(0, 2, 1, 8'b00001100, 1'b1, "hold");
    endtask

    task automatic test_three_input();
        sweep(2, 3, 2, 8'b10010110, 1'b0, "parity3");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_settle0();
        test_mid_reset();
        test_hold_start();
        test_three_input();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
